// File: rtl/net_pixel_plotter.sv
// Net pixel plotter: buffers centre-net y values in a 4-entry FIFO and draws each one
// as a short horizontal run on the VGA adapter write port.
module net_pixel_plotter #(
  parameter logic [7:0]  NET_X   = 8'd79,
  parameter int unsigned NET_W   = 2,
  parameter logic [2:0]  NET_COL = 3'b111,
  parameter logic [6:0]  Y_MAX   = 7'd119
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       in_valid,
  input  logic [6:0] in_y,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] LastCol = 2'(NET_W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] mem_q [4];  // {last, y}
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic [1:0] col_q, col_d;
  logic       fifo_full, fifo_empty, push, pop, clear;
  logic [6:0] head_y;
  logic       head_last;
  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [2:0] colour_d;
  logic       plot_d;

  assign fifo_full  = (count_q == 3'd4);
  assign fifo_empty = (count_q == 3'd0);
  assign in_ready   = (state_q == StRun) && !fifo_full;
  assign push       = in_valid && in_ready;
  assign head_y     = mem_q[rd_ptr_q][6:0];
  assign head_last  = mem_q[rd_ptr_q][7];
  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    pop      = 1'b0;
    clear    = 1'b0;
    plot_d   = 1'b0;
    x_d      = vga_x;
    y_d      = vga_y;
    colour_d = vga_colour;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          clear   = 1'b1;
          col_d   = 2'd0;
        end
      end
      StRun: begin
        if (!fifo_empty) begin
          if (head_y > Y_MAX) begin
            // Out-of-range entries retire in a single silent cycle.
            pop   = 1'b1;
            col_d = 2'd0;
          end else begin
            plot_d   = 1'b1;
            x_d      = NET_X + {6'b0, col_q};
            y_d      = head_y;
            colour_d = NET_COL;
            if (col_q == LastCol) begin
              pop   = 1'b1;
              col_d = 2'd0;
            end else begin
              col_d = col_q + 2'd1;
            end
          end
          if (pop && head_last) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= StIdle;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      col_q      <= 2'd0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      vga_plot   <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      vga_x      <= x_d;
      vga_y      <= y_d;
      vga_colour <= colour_d;
      vga_plot   <= plot_d;
      if (clear) begin
        wr_ptr_q <= 2'd0;
        rd_ptr_q <= 2'd0;
        count_q  <= 3'd0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
        count_q <= count_q + {2'b0, push} - {2'b0, pop};
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_y};
  end

endmodule
